// File: rtl/xorshift32.sv
// Registered 32-bit Marsaglia xorshift generator with seed load/scramble and
// on-demand advance; the state register never holds zero.
module xorshift32 #(
  parameter logic [31:0] RESET_SEED = 32'h0000_0001,
  parameter int          STEPS      = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic        load,
  input  logic        en,
  output logic [31:0] x,
  output logic        valid
);

  logic [31:0] state_q, state_d;
  logic        valid_q, valid_d;
  logic [31:0] seed_sel;

  function automatic logic [31:0] step_f(input logic [31:0] v);
    logic [31:0] t;
    t = v ^ (v << 13);
    t = t ^ (t >> 17);
    return t ^ (t << 5);
  endfunction

  // STEPS is clamped to the supported 1..4 range; unused stages fall away.
  function automatic logic [31:0] scramble(input logic [31:0] v);
    logic [31:0] r;
    r = v;
    for (int i = 0; i < 4; i++) begin
      if (i < STEPS || i == 0) r = step_f(r);
    end
    return r;
  endfunction

  always_comb begin
    seed_sel = (a == 32'd0) ? RESET_SEED : a;
    state_d  = state_q;
    valid_d  = valid_q;
    if (load) begin
      state_d = scramble(seed_sel);
      valid_d = 1'b1;
    end else if (en) begin
      state_d = scramble(state_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RESET_SEED;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
    end
  end

  assign x     = state_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_xorshift32.sv
// Scoreboard bench for xorshift32: three instances (STEPS=1,2,4) share stimulus
// and are checked against an independent model, plus fixed reference values.
module tb_xorshift32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic        en;
  logic [31:0] a;
  logic [31:0] x1, x2, x4;
  logic        v1, v2, v4;

  int checks = 0;
  int errors = 0;

  logic [32:0] q1[$];
  logic [32:0] q2[$];
  logic [32:0] q4[$];

  logic [31:0] mState [3];
  logic        mValid [3];
  int          mSteps [3] = '{1, 2, 4};

  bit seen1 [logic [31:0]];
  bit seen2 [logic [31:0]];
  bit seen4 [logic [31:0]];

  xorshift32 #(.STEPS(1)) dut1 (.clk(clk), .rst_n(rst_n), .a(a), .load(load), .en(en), .x(x1), .valid(v1));
  xorshift32 #(.STEPS(2)) dut2 (.clk(clk), .rst_n(rst_n), .a(a), .load(load), .en(en), .x(x2), .valid(v2));
  xorshift32 #(.STEPS(4)) dut4 (.clk(clk), .rst_n(rst_n), .a(a), .load(load), .en(en), .x(x4), .valid(v4));

  always #5 clk = ~clk;

  function automatic logic [31:0] xsOnce(input logic [31:0] v);
    logic [31:0] t;
    t = v ^ (v << 13);
    t = t ^ (t >> 17);
    return t ^ (t << 5);
  endfunction

  function automatic logic [31:0] xsN(input logic [31:0] v, input int n);
    logic [31:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = xsOnce(r);
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 50) $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Drive one cycle, predict every instance's next state, then compare after the edge.
  task automatic applyStimulus(input logic r, input logic l, input logic e, input logic [31:0] av);
    logic [32:0] exp;
    rst_n = r;
    load  = l;
    en    = e;
    a     = av;
    for (int k = 0; k < 3; k++) begin
      if (!r) begin
        mState[k] = 32'h0000_0001;
        mValid[k] = 1'b0;
      end else if (l) begin
        mState[k] = xsN((av == 32'd0) ? 32'h0000_0001 : av, mSteps[k]);
        mValid[k] = 1'b1;
      end else if (e) begin
        mState[k] = xsN(mState[k], mSteps[k]);
      end
    end
    q1.push_back({mValid[0], mState[0]});
    q2.push_back({mValid[1], mState[1]});
    q4.push_back({mValid[2], mState[2]});
    @(posedge clk);
    #1;
    exp = q1.pop_front();
    checkOutput("sb_x_s1", x1, exp[31:0]);
    checkOutput("sb_valid_s1", {31'd0, v1}, {31'd0, exp[32]});
    exp = q2.pop_front();
    checkOutput("sb_x_s2", x2, exp[31:0]);
    checkOutput("sb_valid_s2", {31'd0, v2}, {31'd0, exp[32]});
    exp = q4.pop_front();
    checkOutput("sb_x_s4", x4, exp[31:0]);
    checkOutput("sb_valid_s4", {31'd0, v4}, {31'd0, exp[32]});
  endtask

  initial begin
    int zeros;
    int hist [4];
    int dup1, dup2, dup4;
    int dev;

    // Reset held for two edges while load/en are asserted
    applyStimulus(1'b0, 1'b1, 1'b1, $urandom);
    applyStimulus(1'b0, 1'b1, 1'b1, $urandom);
    checkOutput("rst_x", x1, 32'h0000_0001);
    checkOutput("rst_valid", {31'd0, v1}, 32'd0);

    // Seed loads, each independent of prior state
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd1);
    checkOutput("load1_x", x1, 32'h0004_2021);
    checkOutput("load1_valid", {31'd0, v1}, 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b1, $urandom);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd2);
    checkOutput("load2_x", x1, 32'h0008_4042);
    applyStimulus(1'b1, 1'b0, 1'b0, $urandom);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd3);
    checkOutput("load3_x", x1, 32'h000C_6063);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
    checkOutput("load0_x", x1, 32'h0004_2021);

    // load and en together: load wins without extra advance
    applyStimulus(1'b1, 1'b0, 1'b1, $urandom);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'd1);
    checkOutput("prio_x", x1, 32'h0004_2021);

    // Reset mid-operation, then free run
    applyStimulus(1'b0, 1'b1, 1'b1, $urandom);
    checkOutput("rst2_x", x1, 32'h0000_0001);
    checkOutput("rst2_valid", {31'd0, v1}, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, $urandom);
    checkOutput("run1_x", x1, 32'h0004_2021);
    checkOutput("run1_valid", {31'd0, v1}, 32'd0);

    zeros = 0;
    for (int b = 0; b < 4; b++) hist[b] = 0;
    for (int i = 0; i < 10000; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, $urandom);
      if (x1 == 32'd0 || x2 == 32'd0 || x4 == 32'd0) zeros++;
      hist[x1[1:0]]++;
    end
    checkOutput("run_zero", zeros, 32'd0);
    for (int b = 0; b < 4; b++) begin
      dev = hist[b] - 2500;
      if (dev < 0) dev = -dev;
      checkOutput($sformatf("hist_bin%0d_in_range", b), (dev <= 125) ? 32'd1 : 32'd0, 32'd1);
    end

    // Seed sweep with distinctness tracking per instance
    dup1 = 0;
    dup2 = 0;
    dup4 = 0;
    for (int i = 0; i <= 32'hFFFF; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, i);
      if (i != 0) begin
        if (seen1.exists(x1)) dup1++;
        if (seen2.exists(x2)) dup2++;
        if (seen4.exists(x4)) dup4++;
        seen1[x1] = 1'b1;
        seen2[x2] = 1'b1;
        seen4[x4] = 1'b1;
      end
    end
    checkOutput("sweep_dup_s1", dup1, 32'd0);
    checkOutput("sweep_dup_s2", dup2, 32'd0);
    checkOutput("sweep_dup_s4", dup4, 32'd0);
    checkOutput("sweep_count_s1", seen1.num(), 32'd65535);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/xorshift32.md
# xorshift32

Registered 32-bit Marsaglia xorshift pseudo-random generator: holds a 32-bit state, scrambles a seed supplied on `a` when loaded, and advances the state on demand. It sits between seed/control logic and consumers of uniformly distributed random words. Consumers may take `x` directly or slice it, for example `x[1:0]` for a uniform value in 0..3. The block is fully synchronous with a single clock domain.

## Interface
Parameters:
- `RESET_SEED`, default `32'h0000_0001`: state value loaded on reset and substituted for a zero seed; must be nonzero.
- `STEPS`, default 1: number of xorshift iterations applied per update, range 1..4, unrolled combinationally.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on the `clk` rising edge.
- `a`  in  32  seed input, sampled when `load`=1.
- `load`  in  1  load-and-scramble seed from `a` this cycle.
- `en`  in  1  advance the current state this cycle.
- `x`  out  32  current state (random word), driven directly from the state register.
- `valid`  out  1  high once a seed has been loaded since reset.

## Operation
- Step function f(v), all 32-bit with truncation and zero-fill shifts, applied in this order:
  - t = v ^ (v << 13)
  - t = t ^ (t >> 17)
  - f = t ^ (t << 5)
- F(v) is f applied `STEPS` times in series.
- Seed sanitising: s_in = (a == 0) ? `RESET_SEED` : a.
- Per rising edge, in priority order:
  1. `rst_n`=0: state <= `RESET_SEED`, `valid` <= 0.
  2. `load`=1: state <= F(s_in), `valid` <= 1. `en` is ignored in this cycle.
  3. `en`=1: state <= F(state). `valid` is unchanged.
  4. Otherwise: state and `valid` hold.
- `x` = state at all times; no combinational path from `a` to `x`.
- The state never becomes 0:
  - f is a bijection on nonzero words, so a nonzero input always gives a nonzero result.
  - A zero seed is replaced by `RESET_SEED` before scrambling.
- Period is 2^32−1 over successive `en` steps with `STEPS`=1.

## Timing
- Latency: 1 cycle. `load` or `en` asserted at edge k makes the new `x` visible immediately after edge k.
- Throughput: one new word per cycle with `en` held high.
- Reset values:
  - `x` = `RESET_SEED`, i.e. 0x00000001 with the default.
  - `valid` = 0.
- Reset mid-operation: a low `rst_n` at an edge overrides `load` and `en` at that same edge.
- The cycle after reset release accepts `load` or `en` normally.
- `load` and `en` asserted together: `load` wins and the state is not additionally advanced.
- `a` is don't-care when `load`=0.
- No handshake: `x` is always valid data. `valid` only flags whether the sequence is user-seeded.

## Test plan
- Reset: hold `rst_n`=0 for 2 edges with `load`=`en`=1 -> `x`=0x00000001, `valid`=0.
- Seed loads: each load takes one cycle and the results must be independent of prior state.
  - `load`=1, `a`=1 -> `x`=0x00042021, `valid`=1.
  - `a`=2 -> `x`=0x00084042.
  - `a`=3 -> `x`=0x000C6063.
- Zero seed: `load`=1, `a`=0 -> `x`=0x00042021 (same as seed 1 with the default `RESET_SEED`).
- Free run from reset: `en`=1 for one cycle -> `x`=0x00042021. Then 10,000 cycles -> `x` never 0, and the `x[1:0]` histogram is within ±5% of 2,500 per bin.
- Priority: with `load`=`en`=1 and `a`=1 -> `x`=0x00042021, not f(0x00042021).
- Sweep: increment `a` every cycle from 0 to 0xFFFF with `load`=1.
  - Compare each `x` against a reference model of F(s_in).
  - All 65,535 nonzero seeds must give distinct outputs.
  - Repeat with `STEPS`=2 and `STEPS`=4.
